// File: rtl/sw_debounce_reader.sv
// Debounced reader for the board slide switches: two-flop synchronizer, per-vector
// stability counter, and a valid/ready change-event register with overrun tracking.
module sw_debounce_reader #(
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned STABLE_CYCLES = 1000,
    localparam int unsigned CNT_W        = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             KEY0,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] sw_stable,
    output logic             chg_valid,
    input  logic             chg_ready,
    output logic [WIDTH-1:0] chg_data,
    output logic [WIDTH-1:0] chg_mask,
    output logic             overrun,
    input  logic             overrun_clr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] count;

    logic             commit;
    logic [WIDTH-1:0] delta;
    logic             coalesce;

    always_comb begin
        commit   = (count == CNT_MAX) && (s2 == cand) && (cand != sw_stable);
        delta    = cand ^ sw_stable;
        coalesce = commit && chg_valid && !chg_ready;
    end

    always_ff @(posedge clk) begin
        if (KEY0) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= SW;
            s2 <= s1;
        end
    end

    // Any movement of the synchronized value restarts the stability window.
    always_ff @(posedge clk) begin
        if (KEY0) begin
            cand  <= '0;
            count <= '0;
        end else if (s2 != cand) begin
            cand  <= s2;
            count <= '0;
        end else if (count != CNT_MAX) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (KEY0) begin
            sw_stable <= '0;
        end else if (commit) begin
            sw_stable <= cand;
        end
    end

    // A commit landing on an unaccepted event merges into it rather than being lost.
    always_ff @(posedge clk) begin
        if (KEY0) begin
            chg_valid <= 1'b0;
            chg_data  <= '0;
            chg_mask  <= '0;
        end else if (commit && (!chg_valid || chg_ready)) begin
            chg_valid <= 1'b1;
            chg_data  <= cand;
            chg_mask  <= delta;
        end else if (commit) begin
            chg_data  <= cand;
            chg_mask  <= chg_mask | delta;
        end else if (chg_valid && chg_ready) begin
            chg_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (KEY0) begin
            overrun <= 1'b0;
        end else if (coalesce) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sw_debounce_reader.sv
// Directed bench for sw_debounce_reader with STABLE_CYCLES=4; inputs and
// checks both happen on the falling clock edge.
module tb_sw_debounce_reader;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         KEY0;
    logic [W-1:0] SW;
    logic [W-1:0] sw_stable;
    logic         chg_valid;
    logic         chg_ready;
    logic [W-1:0] chg_data;
    logic [W-1:0] chg_mask;
    logic         overrun;
    logic         overrun_clr;

    int tests  = 0;
    int failed = 0;
    int first_edge;
    int highs;

    sw_debounce_reader #(.WIDTH(W), .STABLE_CYCLES(4)) dut (
        .clk(clk),
        .KEY0(KEY0),
        .SW(SW),
        .sw_stable(sw_stable),
        .chg_valid(chg_valid),
        .chg_ready(chg_ready),
        .chg_data(chg_data),
        .chg_mask(chg_mask),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chkv(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [W-1:0] st, input logic v,
                           input logic [W-1:0] d, input logic [W-1:0] m, input logic o);
        chkv({tag, ".stable"}, sw_stable, st);
        chkb({tag, ".valid"}, chg_valid, v);
        chkv({tag, ".data"}, chg_data, d);
        chkv({tag, ".mask"}, chg_mask, m);
        chkb({tag, ".overrun"}, overrun, o);
    endtask

    // Counts edges (1-based) until chg_valid first rises, and how many cycles it is high.
    task automatic measure(input int n, output int first, output int hi);
        first = 0;
        hi    = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (chg_valid === 1'b1) begin
                hi++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        KEY0        = 1'b1;
        SW          = '0;
        chg_ready   = 1'b0;
        overrun_clr = 1'b0;
        step(3);
        chk_all("reset", 10'h000, 1'b0, 10'h000, 10'h000, 1'b0);

        // Release with switches already set: first stable value is an event.
        KEY0      = 1'b0;
        SW        = 10'h2AA;
        chg_ready = 1'b1;
        step(6);
        chkb("rel.edge6_valid", chg_valid, 1'b0);
        chkv("rel.edge6_stable", sw_stable, 10'h000);
        step(1);
        chk_all("rel.edge7", 10'h2AA, 1'b1, 10'h2AA, 10'h2AA, 1'b0);
        step(1);
        chkb("rel.edge8_valid", chg_valid, 1'b0);
        chkv("rel.edge8_data_hold", chg_data, 10'h2AA);

        // 3-cycle pulse on SW[0] is too short to commit.
        SW = 10'h2AB;
        step(3);
        SW = 10'h2AA;
        measure(15, first_edge, highs);
        chki("pulse.events", highs, 0);
        chkv("pulse.stable", sw_stable, 10'h2AA);

        SW = 10'h2AB;
        measure(20, first_edge, highs);
        chki("hold.first_edge", first_edge, 7);
        chki("hold.valid_cycles", highs, 1);
        chk_all("hold", 10'h2AB, 1'b0, 10'h2AB, 10'h001, 1'b0);

        // Bring SW[3] low so the bounce can settle it high.
        SW = 10'h2A3;
        measure(20, first_edge, highs);
        chki("b3low.valid_cycles", highs, 1);
        chkv("b3low.mask", chg_mask, 10'h008);

        highs = 0;
        for (int t = 0; t < 14; t++) begin
            SW[3] = ~SW[3];
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                if (chg_valid !== 1'b0) highs++;
            end
        end
        chki("bounce.no_early_event", highs, 0);
        SW[3] = ~SW[3];
        measure(20, first_edge, highs);
        chki("bounce.first_edge", first_edge, 7);
        chki("bounce.valid_cycles", highs, 1);
        chk_all("bounce", 10'h2AB, 1'b0, 10'h2AB, 10'h008, 1'b0);

        // Back to 2AA, then coalesce two changes while the consumer stalls.
        SW = 10'h2AA;
        step(20);
        chkv("base.stable", sw_stable, 10'h2AA);
        chg_ready = 1'b0;
        SW        = 10'h3AA;
        step(7);
        chk_all("stall1", 10'h3AA, 1'b1, 10'h3AA, 10'h100, 1'b0);
        SW = 10'h3AB;
        step(6);
        chkv("stall.data_hold", chg_data, 10'h3AA);
        chkv("stall.mask_hold", chg_mask, 10'h100);
        step(1);
        chk_all("coalesce", 10'h3AB, 1'b1, 10'h3AB, 10'h101, 1'b1);
        step(5);
        chkb("coalesce.valid_holds", chg_valid, 1'b1);
        chg_ready = 1'b1;
        step(1);
        chk_all("drain", 10'h3AB, 1'b0, 10'h3AB, 10'h101, 1'b1);
        overrun_clr = 1'b1;
        step(1);
        overrun_clr = 1'b0;
        chkb("ovr_clr", overrun, 1'b0);

        // Commit lands in the same cycle as a transfer.
        chg_ready = 1'b0;
        SW        = 10'h3AA;
        step(7);
        chk_all("pend", 10'h3AA, 1'b1, 10'h3AA, 10'h001, 1'b0);
        SW = 10'h2AA;
        step(6);
        chkb("pend.edge6_valid", chg_valid, 1'b1);
        chkv("pend.edge6_data", chg_data, 10'h3AA);
        chg_ready = 1'b1;
        step(1);
        chk_all("xfer_commit", 10'h2AA, 1'b1, 10'h2AA, 10'h100, 1'b0);
        step(1);
        chkb("xfer_commit.drained", chg_valid, 1'b0);

        // Reset with a coalesced event pending and a count in progress.
        chg_ready = 1'b0;
        SW        = 10'h3AA;
        step(7);
        SW = 10'h3AB;
        step(7);
        chk_all("prerst", 10'h3AB, 1'b1, 10'h3AB, 10'h101, 1'b1);
        SW = 10'h2AB;
        step(3);
        KEY0 = 1'b1;
        step(1);
        chk_all("midrst", 10'h000, 1'b0, 10'h000, 10'h000, 1'b0);
        KEY0      = 1'b0;
        chg_ready = 1'b1;
        measure(20, first_edge, highs);
        chki("rerpt.first_edge", first_edge, 7);
        chki("rerpt.valid_cycles", highs, 1);
        chk_all("rerpt", 10'h2AB, 1'b0, 10'h2AB, 10'h2AB, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sw_debounce_reader.md
Name: sw_debounce_reader

Overview:
- Input-side counterpart to the LED output path: samples the raw board slide switches and produces clean, debounced switch state plus change events.
- Events use a valid/ready handshake, so the lab datapath consumes switch changes as transactions instead of polling raw, bouncing inputs.
- Sits between the SW pins and the lab core, beside the LED driver logic.

Parameters:
- WIDTH, 10, number of switch inputs.
- STABLE_CYCLES, 1000, consecutive clk cycles a synchronized value must hold before it is accepted (minimum 2).
- CNT_W, $clog2(STABLE_CYCLES), width of the stability counter (derived, not overridden).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- KEY0  input  1  synchronous, active-high reset.
- SW  input  WIDTH  raw asynchronous switch levels.
- sw_stable  output  WIDTH  current debounced switch value.
- chg_valid  output  1  change event pending.
- chg_ready  input  1  consumer accepts event; transfer occurs when chg_valid && chg_ready at a rising edge.
- chg_data  output  WIDTH  debounced value carried by the pending event.
- chg_mask  output  WIDTH  bits that differ from the value before the event (merged if coalesced).
- overrun  output  1  sticky: an event was coalesced into an unaccepted one.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (KEY0=1 at a rising edge) clears everything to 0: both synchronizer stages, candidate, counter, sw_stable, chg_valid, chg_data, chg_mask, overrun. Reset wins over all other activity, including mid-count and mid-handshake; a pending event is dropped.
- Synchronizer: two flops per bit, SW -> s1 -> s2. No logic acts on SW or s1 directly.
- Candidate/counter:
  - s2 != candidate: candidate <= s2, count <= 0.
  - Otherwise: count increments, saturating at STABLE_CYCLES-1.
- Commit: on a cycle where count == STABLE_CYCLES-1, s2 == candidate, and candidate != sw_stable:
  - sw_stable <= candidate.
  - An event is generated with new = candidate, delta = candidate ^ sw_stable(old).
- Latency: SW changes before edge 1. sw_stable and chg_valid update at edge STABLE_CYCLES+3. For STABLE_CYCLES=4 that is edge 7.
- Bounce: any change of s2 before commit restarts the count. A pulse shorter than STABLE_CYCLES cycles after synchronization produces no commit and no event.
- Event register: each rising edge takes the first matching case below.
  - Event generated and (chg_valid==0 or chg_ready==1): chg_data <= new, chg_mask <= delta, chg_valid <= 1.
  - Event generated, chg_valid==1, chg_ready==0: chg_data <= new, chg_mask <= chg_mask | delta, chg_valid stays 1, overrun <= 1.
  - No event, chg_valid && chg_ready: chg_valid <= 0; chg_data and chg_mask hold.
  - Otherwise hold.
- Handshake: chg_data and chg_mask are stable while chg_valid=1 && chg_ready=0, except on coalesce. chg_valid never drops without a transfer or reset.
- overrun: set and overrun_clr asserted in the same cycle -> set wins. overrun_clr alone -> 0.
- Reset release with SW nonzero: since sw_stable resets to 0, the first stable value generates an event.
- No combinational path from any input to any output.

Test Plan:
- Reset, then release KEY0 with SW=10'b1010101010, chg_ready=1, STABLE_CYCLES=4 -> chg_valid high at edge 7 after release, for exactly 1 cycle; chg_data=10'h2AA, chg_mask=10'h2AA, sw_stable=10'h2AA, overrun=0.
- From stable 10'h2AA, SW[0] pulses high for 3 cycles (STABLE_CYCLES=4) -> no event, sw_stable unchanged. SW[0] held 20 cycles -> one event: chg_data=10'h2AB, chg_mask=10'h001.
- Bounce: SW[3] toggles every 2 cycles for 30 cycles, then settles at 1 -> exactly one event, STABLE_CYCLES+3 edges after the final toggle, chg_mask=10'h008.
- chg_ready=0: change SW 10'h2AA -> 10'h3AA, then after commit -> 10'h3AB -> chg_valid stays 1; chg_data=10'h3AB, chg_mask=10'h101, overrun=1. Raise chg_ready -> one transfer, then chg_valid=0. Pulse overrun_clr -> overrun=0.
- Commit in the same cycle as a transfer (chg_valid=1, chg_ready=1) -> new event loaded, chg_valid remains 1, overrun stays 0.
- Assert KEY0 mid-count and with an event pending -> all outputs 0 next edge. After release, the stable SW value is re-reported as a fresh event.
